// File: rtl/bidir_pad_ctrl.sv
// bidir_pad_ctrl: half-duplex sequencer for one BIDIR cell in INOUT mode.
// It shares the pad between a TX and an RX requester using round-robin
// arbitration. TX words are serialised MSB first and RX words are
// deserialised MSB first. Guard cycles at each turnaround keep IE and INEN
// from ever being high together.
//
// Ports:
//   IQC, IQR          clock, asynchronous active-high reset
//   tx_valid/tx_data  TX word offer; tx_ready (combinational) marks the accept
//   rx_start          one-cycle request to receive a word
//   rx_valid/rx_data  registered one-cycle pulse with the received word
//   busy              sequencer is not idle
//   IE, OQI, INEN     pad output enable, output data and input enable
//   IZ                pad input data
module bidir_pad_ctrl #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic             IQC,
    input  logic             IQR,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    input  logic             rx_start,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             IE,
    output logic             OQI,
    output logic             INEN,
    input  logic             IZ
);

    localparam int unsigned CNT_W = 5;
    localparam bit HAS_GUARD = (GUARD_CYCLES != 0);
    localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD =
        (GUARD_CYCLES == 0) ? '0 : CNT_W'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_SHIFT,
        S_TX_GUARD,
        S_RX_SETTLE,
        S_RX_SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic               last_rx_q, last_rx_d;
    logic               ie_q, ie_d;
    logic               oqi_q, oqi_d;
    logic               inen_q, inen_d;
    logic               rx_valid_q, rx_valid_d;
    logic [WIDTH-1:0]   rx_data_q, rx_data_d;

    logic               grant_tx_c;
    logic               grant_rx_c;
    logic [WIDTH-1:0]   rx_shift_c;

    // Round-robin: a tie goes to whichever side did not win last time.
    assign grant_tx_c = (state_q == S_IDLE) && tx_valid && (!rx_start || last_rx_q);
    assign grant_rx_c = (state_q == S_IDLE) && rx_start && !grant_tx_c;

    // Shift the pad bit in at the LSB.
    assign rx_shift_c = WIDTH'({sreg_q, IZ});

    // Next-state and registered pad controls.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sreg_d     = sreg_q;
        last_rx_d  = last_rx_q;
        ie_d       = 1'b0;
        oqi_d      = 1'b0;
        inen_d     = 1'b0;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;

        case (state_q)
            S_IDLE: begin
                if (grant_tx_c) begin
                    // MSB goes straight to the pad; the remainder waits in sreg.
                    state_d   = S_TX_SHIFT;
                    cnt_d     = SHIFT_LOAD;
                    sreg_d    = tx_data << 1;
                    ie_d      = 1'b1;
                    oqi_d     = tx_data[WIDTH-1];
                    last_rx_d = 1'b0;
                end else if (grant_rx_c) begin
                    last_rx_d = 1'b1;
                    inen_d    = 1'b1;
                    if (HAS_GUARD) begin
                        state_d = S_RX_SETTLE;
                        cnt_d   = GUARD_LOAD;
                    end else begin
                        state_d = S_RX_SHIFT;
                        cnt_d   = SHIFT_LOAD;
                    end
                end
            end

            S_TX_SHIFT: begin
                if (cnt_q == '0) begin
                    // Last bit has been on the pad for a full cycle; release it.
                    if (HAS_GUARD) begin
                        state_d = S_TX_GUARD;
                        cnt_d   = GUARD_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    ie_d   = 1'b1;
                    oqi_d  = sreg_q[WIDTH-1];
                    sreg_d = sreg_q << 1;
                end
            end

            S_TX_GUARD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_RX_SETTLE: begin
                inen_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_RX_SHIFT;
                    cnt_d   = SHIFT_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_RX_SHIFT: begin
                sreg_d = rx_shift_c;
                if (cnt_q == '0) begin
                    state_d    = S_IDLE;
                    rx_data_d  = rx_shift_c;
                    rx_valid_d = 1'b1;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    inen_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge IQC or posedge IQR) begin
        if (IQR) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sreg_q     <= '0;
            last_rx_q  <= 1'b1;
            ie_q       <= 1'b0;
            oqi_q      <= 1'b0;
            inen_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sreg_q     <= sreg_d;
            last_rx_q  <= last_rx_d;
            ie_q       <= ie_d;
            oqi_q      <= oqi_d;
            inen_q     <= inen_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign tx_ready = grant_tx_c;
    assign busy     = (state_q != S_IDLE);
    assign IE       = ie_q;
    assign OQI      = oqi_q;
    assign INEN     = inen_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_bidir_pad_ctrl.sv
// Testbench for bidir_pad_ctrl: a table of single transactions on a
// GUARD_CYCLES=2 instance, plus hand-written sequences for rx_start while
// busy, asynchronous reset mid-word and G=0 back-to-back turnarounds.
module tb_bidir_pad_ctrl;

    localparam int unsigned W = 8;
    localparam int unsigned G = 2;

    logic clk = 1'b0;
    logic rst;

    logic         tx_valid, rx_start, iz;
    logic [W-1:0] tx_data;
    logic         tx_ready, rx_valid, busy, ie, oqi, inen;
    logic [W-1:0] rx_data;

    logic         z_tx_valid, z_rx_start, z_iz;
    logic [W-1:0] z_tx_data;
    logic         z_tx_ready, z_rx_valid, z_busy, z_ie, z_oqi, z_inen;
    logic [W-1:0] z_rx_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bidir_pad_ctrl #(.WIDTH(W), .GUARD_CYCLES(G)) dut (
        .IQC(clk), .IQR(rst),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_start(rx_start), .rx_valid(rx_valid), .rx_data(rx_data),
        .busy(busy), .IE(ie), .OQI(oqi), .INEN(inen), .IZ(iz)
    );

    bidir_pad_ctrl #(.WIDTH(W), .GUARD_CYCLES(0)) dut0 (
        .IQC(clk), .IQR(rst),
        .tx_valid(z_tx_valid), .tx_data(z_tx_data), .tx_ready(z_tx_ready),
        .rx_start(z_rx_start), .rx_valid(z_rx_valid), .rx_data(z_rx_data),
        .busy(z_busy), .IE(z_ie), .OQI(z_oqi), .INEN(z_inen), .IZ(z_iz)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Pad must never be driven while input sampling is enabled.
    always @(negedge clk) begin
        if (!rst) begin
            chk1("ie_inen_excl", ie & inen, 1'b0);
            chk1("z_ie_inen_excl", z_ie & z_inen, 1'b0);
        end
    end

    typedef struct {
        logic         tx_v;
        logic         rx_s;
        logic [W-1:0] data;      // tx_data, and the word driven on IZ for RX
        logic         exp_tx;    // 1: TX expected to win, 0: RX expected
        logic [W-1:0] exp_word;  // expected OQI sequence or rx_data
    } vec_t;

    vec_t vecs[9];

    // One transaction from IDLE, checked cycle by cycle.
    task automatic run_txn(input int idx, input vec_t v);
        logic [W-1:0] word;
        @(posedge clk); #1;
        tx_valid = v.tx_v; tx_data = v.data; rx_start = v.rx_s; iz = 1'b0;
        @(negedge clk);
        chk1($sformatf("v%0d_tx_ready", idx), tx_ready, v.exp_tx);
        chk1($sformatf("v%0d_idle_busy", idx), busy, 1'b0);
        @(posedge clk); #1;
        tx_valid = 1'b0; rx_start = 1'b0;
        if (v.exp_tx) begin
            word = '0;
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                chk1($sformatf("v%0d_ie_shift%0d", idx, i), ie, 1'b1);
                chk1($sformatf("v%0d_inen_shift%0d", idx, i), inen, 1'b0);
                word = {word[W-2:0], oqi};
                @(posedge clk); #1;
            end
            chkw($sformatf("v%0d_oqi_word", idx), word, v.exp_word);
            for (int g = 0; g < G; g++) begin
                @(negedge clk);
                chk1($sformatf("v%0d_guard_ie%0d", idx, g), ie, 1'b0);
                chk1($sformatf("v%0d_guard_oqi%0d", idx, g), oqi, 1'b0);
                chk1($sformatf("v%0d_guard_busy%0d", idx, g), busy, 1'b1);
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk1($sformatf("v%0d_tx_done_busy", idx), busy, 1'b0);
            chk1($sformatf("v%0d_tx_done_ie", idx), ie, 1'b0);
        end else begin
            for (int c = 1; c <= int'(G + W); c++) begin
                if (c >= int'(G + 1)) iz = v.data[int'(G + W) - c];
                @(negedge clk);
                chk1($sformatf("v%0d_inen_c%0d", idx, c), inen, 1'b1);
                chk1($sformatf("v%0d_rx_valid_c%0d", idx, c), rx_valid, 1'b0);
                @(posedge clk); #1;
            end
            iz = 1'b0;
            @(negedge clk);
            chk1($sformatf("v%0d_rx_valid", idx), rx_valid, 1'b1);
            chkw($sformatf("v%0d_rx_data", idx), rx_data, v.exp_word);
            chk1($sformatf("v%0d_rx_done_inen", idx), inen, 1'b0);
            chk1($sformatf("v%0d_rx_done_busy", idx), busy, 1'b0);
            @(posedge clk); #1;
            @(negedge clk);
            chk1($sformatf("v%0d_rx_valid_pulse", idx), rx_valid, 1'b0);
            chkw($sformatf("v%0d_rx_data_hold", idx), rx_data, v.exp_word);
        end
    endtask

    initial begin
        logic [W-1:0] rxw;

        //          tx_v  rx_s  data   exp_tx exp_word
        vecs[0] = '{1'b1, 1'b1, 8'h96, 1'b1, 8'h96};  // tie from reset -> TX
        vecs[1] = '{1'b1, 1'b1, 8'hC3, 1'b0, 8'hC3};  // tie after TX -> RX
        vecs[2] = '{1'b1, 1'b1, 8'h0F, 1'b1, 8'h0F};  // tie after RX -> TX
        vecs[3] = '{1'b1, 1'b0, 8'hA5, 1'b1, 8'hA5};  // single TX
        vecs[4] = '{1'b0, 1'b1, 8'h3C, 1'b0, 8'h3C};  // single RX
        vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[6] = '{1'b0, 1'b1, 8'hFF, 1'b0, 8'hFF};
        vecs[7] = '{1'b0, 1'b1, 8'h81, 1'b0, 8'h81};
        vecs[8] = '{1'b1, 1'b1, 8'h5A, 1'b1, 8'h5A};  // tie after RX -> TX

        rst = 1'b1;
        tx_valid = 1'b0; rx_start = 1'b0; iz = 1'b0; tx_data = '0;
        z_tx_valid = 1'b0; z_rx_start = 1'b0; z_iz = 1'b0; z_tx_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_ie", ie, 1'b0);
        chk1("rst_oqi", oqi, 1'b0);
        chk1("rst_inen", inen, 1'b0);
        chk1("rst_rx_valid", rx_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chkw("rst_rx_data", rx_data, 8'h00);
        chk1("rst_z_busy", z_busy, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run_txn(i, vecs[i]);

        // rx_start pulsed while TX is shifting is dropped.
        @(posedge clk); #1;
        tx_valid = 1'b1; tx_data = 8'h3C;
        @(negedge clk);
        chk1("busyrx_tx_ready", tx_ready, 1'b1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        @(posedge clk); #1;
        rx_start = 1'b1;
        @(negedge clk);
        chk1("busyrx_busy", busy, 1'b1);
        chk1("busyrx_ready", tx_ready, 1'b0);
        @(posedge clk); #1;
        rx_start = 1'b0;
        for (int c = 0; c < int'(W + G + 4); c++) begin
            @(negedge clk);
            chk1($sformatf("busyrx_inen%0d", c), inen, 1'b0);
            chk1($sformatf("busyrx_rx_valid%0d", c), rx_valid, 1'b0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk1("busyrx_idle", busy, 1'b0);

        // Asynchronous reset in the middle of a TX word (bit 4 on the pad).
        @(posedge clk); #1;
        tx_valid = 1'b1; tx_data = 8'hFF;
        @(negedge clk);
        chk1("arst_tx_ready", tx_ready, 1'b1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk1("arst_pre_ie", ie, 1'b1);
        chk1("arst_pre_oqi", oqi, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("arst_ie", ie, 1'b0);
        chk1("arst_oqi", oqi, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_inen", inen, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_txn(9, '{1'b1, 1'b0, 8'hA5, 1'b1, 8'hA5});

        // G=0: TX FF, RX in the first idle cycle, TX in the rx_valid cycle.
        @(posedge clk); #1;
        z_tx_valid = 1'b1; z_tx_data = 8'hFF;
        @(negedge clk);
        chk1("g0_tx_ready", z_tx_ready, 1'b1);
        @(posedge clk); #1;
        z_tx_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk1($sformatf("g0_ie%0d", i), z_ie, 1'b1);
            chk1($sformatf("g0_oqi%0d", i), z_oqi, 1'b1);
            @(posedge clk); #1;
        end
        // IE dropped on the edge that entered IDLE; request RX right away.
        z_rx_start = 1'b1;
        @(negedge clk);
        chk1("g0_turn_ie", z_ie, 1'b0);
        chk1("g0_turn_busy", z_busy, 1'b0);
        chk1("g0_turn_inen", z_inen, 1'b0);
        @(posedge clk); #1;
        z_rx_start = 1'b0;
        rxw = 8'h96;
        for (int c = 1; c <= int'(W); c++) begin
            z_iz = rxw[int'(W) - c];
            @(negedge clk);
            chk1($sformatf("g0_inen%0d", c), z_inen, 1'b1);
            chk1($sformatf("g0_rx_ie%0d", c), z_ie, 1'b0);
            chk1($sformatf("g0_rx_valid%0d", c), z_rx_valid, 1'b0);
            @(posedge clk); #1;
        end
        z_iz = 1'b0;
        z_tx_valid = 1'b1; z_tx_data = 8'h80;
        @(negedge clk);
        chk1("g0_rx_valid", z_rx_valid, 1'b1);
        chkw("g0_rx_data", z_rx_data, 8'h96);
        chk1("g0_rx_inen", z_inen, 1'b0);
        chk1("g0_rx_busy", z_busy, 1'b0);
        chk1("g0_b2b_tx_ready", z_tx_ready, 1'b1);
        @(posedge clk); #1;
        z_tx_valid = 1'b0;
        @(negedge clk);
        chk1("g0_tx2_ie0", z_ie, 1'b1);
        chk1("g0_tx2_oqi0", z_oqi, 1'b1);
        chk1("g0_tx2_rx_valid", z_rx_valid, 1'b0);
        for (int i = 1; i < W; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk1($sformatf("g0_tx2_ie%0d", i), z_ie, 1'b1);
            chk1($sformatf("g0_tx2_oqi%0d", i), z_oqi, 1'b0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk1("g0_tx2_end_ie", z_ie, 1'b0);
        chk1("g0_tx2_end_busy", z_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
